// File: rtl/qs_fifo_packer.sv
// Packs PACK consecutive DATA_W-bit entries from a show-ahead FIFO read port into one wide output word. A flush pulse emits a partially filled word.
// Latency: out_valid_o rises the cycle after the edge that pops the last entry of a word, or the cycle after the flush edge.
// Backpressure: the packer holds the word while out_ready_i is low and does not pop the FIFO until the word is accepted.
module qs_fifo_packer #(
    parameter  int DATA_W = 8,
    parameter  int PACK   = 4,
    localparam int CNT_W  = $clog2(PACK + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty_i,
    input  logic [DATA_W-1:0]        fifo_data_i,
    output logic                     fifo_pop_o,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    output logic [DATA_W*PACK-1:0]   out_data_o,
    output logic [CNT_W-1:0]         out_cnt_o,
    input  logic                     out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W*PACK-1:0]   data_q, data_d;
    logic                     pop;

    // Pop whenever a word is being assembled and the FIFO has a head entry.
    // Reset gates the pop so no entry is consumed while reset is held.
    assign pop        = ~reset && (state_q != S_OUT) && ~fifo_empty_i;
    assign fifo_pop_o = pop;

    assign out_valid_o = (state_q == S_OUT);
    assign out_data_o  = data_q;
    assign out_cnt_o   = cnt_q;

    // Next-state logic: fill lanes in pop order, close the word when full or flushed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // Flush is ignored here: there is nothing to emit.
                if (pop) begin
                    data_d[0 +: DATA_W] = fifo_data_i;
                    cnt_d               = CNT_W'(1);
                    state_d             = S_FILL;
                end
            end
            S_FILL: begin
                if (pop) begin
                    for (int k = 0; k < PACK; k++) begin
                        if (CNT_W'(k) == cnt_q) begin
                            data_d[k*DATA_W +: DATA_W] = fifo_data_i;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    // A flush on the completing pop simply yields a full word.
                    if ((cnt_q + 1'b1) == PACK_C || flush_i) begin
                        state_d = S_OUT;
                    end
                end else if (flush_i) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // Word and count stay frozen until the sink takes them.
                if (out_ready_i) begin
                    cnt_d   = '0;
                    data_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                data_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, lane count and packed word registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_qs_fifo_packer.sv
// Directed bench for qs_fifo_packer with a behavioural show-ahead FIFO.
// Inputs change 1 time unit after the rising edge; pops and accepted words are sampled at the edge.
// Each check is an immediate assertion that counts failures.
module tb_qs_fifo_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_pop;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_cnt;
    logic        out_ready;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [7:0]  fq[$];
    logic [31:0] wq[$];
    logic [2:0]  cq[$];

    qs_fifo_packer #(.DATA_W(8), .PACK(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_pop_o   (fifo_pop),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_cnt_o    (out_cnt),
        .out_ready_i  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        upd_fifo();
    endtask

    // One clock: sample pop/acceptance at the edge, then update the FIFO model.
    task automatic tick();
        logic        p;
        logic        a;
        logic [31:0] d;
        logic [2:0]  c;
        @(posedge clk);
        p = fifo_pop;
        a = out_valid & out_ready;
        d = out_data;
        c = out_cnt;
        #1;
        if (p && fq.size() != 0) begin
            void'(fq.pop_front());
            pops++;
        end
        if (a) begin
            wq.push_back(d);
            cq.push_back(c);
        end
        upd_fifo();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait (bounded) for one accepted word and compare it.
    task automatic expect_word(input string tag, input logic [31:0] wexp, input logic [2:0] cexp);
        for (int i = 0; i < 30 && wq.size() == 0; i++) tick();
        chk({tag, "_nwords"}, 64'(wq.size()), 64'd1);
        if (wq.size() != 0) begin
            chk({tag, "_data"}, 64'(wq.pop_front()), 64'(wexp));
            chk({tag, "_cnt"}, 64'(cq.pop_front()), 64'(cexp));
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fq.push_back(8'h55);
        upd_fifo();

        // 1: reset held two cycles with a non-empty FIFO
        ticks(2);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_cnt",   64'(out_cnt),   64'd0);
        chk("rst_pop",   64'(fifo_pop),  64'd0);
        chk("rst_npops", 64'(pops),      64'd0);
        fq.delete();
        upd_fifo();
        reset = 1'b0;
        tick();

        // 2: full word with ready high
        out_ready = 1'b1;
        pops = 0;
        push(8'hAB); push(8'hCC); push(8'h12); push(8'h34);
        expect_word("full", 32'h3412CCAB, 3'd4);
        chk("full_npops", 64'(pops), 64'd4);
        chk("full_empty", 64'(fifo_empty), 64'd1);
        chk("full_valid_after", 64'(out_valid), 64'd0);

        // 3: backpressure, extra entries must stay in the FIFO
        out_ready = 1'b0;
        pops = 0;
        push(8'hAB); push(8'hCC); push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        ticks(4);
        chk("bp_valid_rise", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_pop_low", 64'(fifo_pop), 64'd0);
            tick();
        end
        chk("bp_valid_held", 64'(out_valid), 64'd1);
        chk("bp_data_held",  64'(out_data),  64'h3412CCAB);
        chk("bp_npops",      64'(pops),      64'd4);
        chk("bp_fifo_left",  64'(fq.size()), 64'd2);
        chk("bp_nwords0",    64'(wq.size()), 64'd0);
        out_ready = 1'b1;
        expect_word("bp", 32'h3412CCAB, 3'd4);

        // 4: partial flush of the two remaining entries, then flush in IDLE
        ticks(2);
        chk("pf_empty", 64'(fifo_empty), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("pflush", 32'h00007856, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ticks(3);
        chk("idle_flush_nwords", 64'(wq.size()), 64'd0);
        chk("idle_flush_valid",  64'(out_valid), 64'd0);

        // flush on the same edge as a non-completing pop includes that entry
        push(8'hAB); push(8'hCC); push(8'h12);
        ticks(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("flush_pop", 32'h0012CCAB, 3'd3);

        // flush on the completing pop gives a normal full word
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        ticks(3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_word("flush_full", 32'h04030201, 3'd4);
        ticks(3);
        chk("flush_full_noextra", 64'(wq.size()), 64'd0);

        // 5: starvation mid-word
        push(8'hAB);
        ticks(10);
        chk("starve_valid",  64'(out_valid), 64'd0);
        chk("starve_nwords", 64'(wq.size()), 64'd0);
        push(8'hCC); push(8'h12); push(8'h34);
        expect_word("starve", 32'h3412CCAB, 3'd4);

        // 6: reset mid-word drops the partial lanes
        pops = 0;
        push(8'hAA); push(8'hBB);
        ticks(2);
        chk("mr_npops", 64'(pops), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_cnt",  64'(out_cnt),  64'd0);
        chk("mr_data", 64'(out_data), 64'd0);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_word("mr", 32'h44332211, 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
